keypad_seq_entry: RTL and testbench

Scans a 4x4 hex keypad, debounces key presses and shifts each accepted hex digit into an N-bit digit sequence, one digit per `WIDTH` bits. It is the input-side counterpart of the marquee display path. Its `seq` output feeds the marquee's `seq` input directly, so digits typed on the keypad appear on the 7-segment display. It runs in the `clk_high` scan-clock domain.

---
 rtl/keypad_pkg.sv | 8 +
 rtl/keypad_seq_entry_if.sv | 12 +
 rtl/keypad_scan.sv | 47 ++++
 rtl/keypad_seq_entry.sv | 83 ++++++++
 tb/tb_keypad_seq_entry.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner and sequence entry
package keypad_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_SLOT = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} kp_state_e;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} kp_result_e;
endpackage

// File: rtl/keypad_seq_entry_if.sv
// keypad_seq_entry_if: keypad pins, clear and digit-sequence outputs of the entry block
interface keypad_seq_entry_if #(parameter int N = 32);
  logic [3:0] row;
  logic [3:0] col;
  logic clear;
  logic [N-1:0] seq;
  logic key_valid;
  logic [3:0] key_code;
  logic full;
  modport master(output row, clear, input col, seq, key_valid, key_code, full);
  modport slave(input row, clear, output col, seq, key_valid, key_code, full);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: row synchroniser, column scan and per-round hit accumulation
module keypad_scan
  import keypad_pkg::*;
(
  input  logic       clk_high,
  input  logic       sys_rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       round_done,
  output kp_result_e result,
  output logic [3:0] code
);
  logic [3:0] sync1_q, sync2_q, sc_q, sc_d, code_q, code_d, m_code;
  logic [1:0] hits_q, hits_d, m_hits, first_row;
  logic [2:0] col_hits, sum;
  logic sample;
  always_ff @(posedge clk_high or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      sc_q <= '0;
      hits_q <= '0;
      code_q <= '0;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      sc_q <= sc_d;
      hits_q <= hits_d;
      code_q <= code_d;
    end
  assign col = ~(4'b0001 << sc_q[3:2]);
  always_comb begin
    sample = sc_q[1:0] == 2'(KP_SLOT - 1);
    col_hits = {2'b0, ~sync2_q[0]} + {2'b0, ~sync2_q[1]} + {2'b0, ~sync2_q[2]} + {2'b0, ~sync2_q[3]};
    first_row = !sync2_q[0] ? 2'd0 : !sync2_q[1] ? 2'd1 : !sync2_q[2] ? 2'd2 : 2'd3;
    sum = {1'b0, hits_q} + (sample ? col_hits : 3'd0);
    m_hits = sum >= 3'd2 ? 2'd2 : sum[1:0];
    // code = 4*row + col, kept only for the first hit of the round
    m_code = (sample && hits_q == 2'd0) ? {first_row, sc_q[3:2]} : code_q;
    round_done = sc_q == 4'd15;
    result = m_hits == 2'd0 ? RES_NONE : m_hits == 2'd1 ? RES_SINGLE : RES_MULTI;
    code = m_code;
    sc_d = sc_q + 4'd1;
    hits_d = round_done ? 2'd0 : m_hits;
    code_d = round_done ? 4'd0 : m_code;
  end
endmodule

// File: rtl/keypad_seq_entry.sv
// keypad_seq_entry: debounces scanned key rounds and shifts accepted digits into seq
module keypad_seq_entry
  import keypad_pkg::*;
#(
  parameter int N        = 32,
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 4
) (
  input logic                clk_high,
  input logic                sys_rst_n,
  keypad_seq_entry_if.slave  bus
);
  localparam int DIGITS = N / WIDTH;
  localparam int CW = $clog2(DIGITS + 1);
  kp_state_e state_q, state_d;
  kp_result_e result;
  logic round_done, accept;
  logic [3:0] code, cand_q, cand_d, cnt_q, cnt_d, run_cnt, key_code_q, key_code_d;
  logic [N-1:0] seq_q, seq_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic key_valid_q, key_valid_d;
  keypad_scan u_scan (
    .clk_high  (clk_high),
    .sys_rst_n (sys_rst_n),
    .row       (bus.row),
    .col       (bus.col),
    .round_done(round_done),
    .result    (result),
    .code      (code)
  );
  always_ff @(posedge clk_high or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cand_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
      dcnt_q <= '0;
      key_valid_q <= 1'b0;
      key_code_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
      dcnt_q <= dcnt_d;
      key_valid_q <= key_valid_d;
      key_code_q <= key_code_d;
    end
  assign run_cnt = (state_q == ST_DEBOUNCE && code == cand_q) ? cnt_q + 4'd1 : 4'd1;
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    if (round_done)
      case (state_q)
        ST_IDLE, ST_DEBOUNCE: begin
          cand_d = result == RES_SINGLE ? code : cand_q;
          cnt_d = result == RES_SINGLE ? run_cnt : cnt_q;
          state_d = result != RES_SINGLE ? ST_IDLE : accept ? ST_PRESSED : ST_DEBOUNCE;
        end
        ST_PRESSED: begin
          cnt_d = result == RES_NONE ? 4'd1 : cnt_q;
          state_d = result != RES_NONE ? ST_PRESSED : DEBOUNCE == 1 ? ST_IDLE : ST_RELEASE;
        end
        default: begin
          cnt_d = result == RES_NONE ? cnt_q + 4'd1 : cnt_q;
          state_d = result != RES_NONE ? ST_PRESSED : (cnt_q + 4'd1 == 4'(DEBOUNCE)) ? ST_IDLE : ST_RELEASE;
        end
      endcase
  end
  always_comb begin
    accept = round_done && result == RES_SINGLE && (state_q == ST_IDLE || state_q == ST_DEBOUNCE) && run_cnt == 4'(DEBOUNCE);
    key_valid_d = accept;
    key_code_d = accept ? code : key_code_q;
    // clear takes priority over a same-edge accept for the sequence and count
    seq_d = bus.clear ? '0 : accept ? {seq_q[N-WIDTH-1:0], WIDTH'(code)} : seq_q;
    dcnt_d = bus.clear ? '0 : (accept && dcnt_q != CW'(DIGITS)) ? dcnt_q + CW'(1) : dcnt_q;
  end
  assign bus.seq = seq_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code = key_code_q;
  assign bus.full = dcnt_q == CW'(DIGITS);
endmodule

// File: tb/tb_keypad_seq_entry.sv
// tb_keypad_seq_entry: directed keypad scenarios checked against a round-level behavioural model
module tb_keypad_seq_entry;
  localparam int N = 32, DB = 4;
  logic clk_high = 1'b0, sys_rst_n = 1'b0;
  logic [15:0] pressed = '0;
  int vectors = 0, miscompares = 0, cyc = 0;
  int run = 0, run_code = -1, empty = 0, ndig = 0;
  bit locked = 0, exp_kv = 0;
  logic [3:0] exp_code = '0;
  logic [N-1:0] exp_seq = '0;

  keypad_seq_entry_if #(.N(N)) kif();
  keypad_seq_entry #(.N(N), .WIDTH(4), .DEBOUNCE(DB)) dut (
    .clk_high (clk_high),
    .sys_rst_n(sys_rst_n),
    .bus      (kif)
  );

  always #5 clk_high = ~clk_high;

  function automatic logic [3:0] row_pins(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[4*ri+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction
  assign kif.row = row_pins(pressed, kif.col);

  always @(posedge clk_high or negedge sys_rst_n) cyc <= sys_rst_n ? cyc + 1 : 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_high)
    if (sys_rst_n) begin
      logic [3:0] ecol;
      ecol = ~(4'b0001 << cyc[3:2]);
      chk("col", kif.col, ecol);
      chk("key_valid", kif.key_valid, exp_kv);
      chk("key_code", kif.key_code, exp_code);
      chk("seq", kif.seq, exp_seq);
      chk("full", kif.full, ndig >= N / 4);
    end

  task automatic model_round(input logic [15:0] k, input bit clr);
    int n = $countones(k);
    int first = -1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[4*r+c] && first < 0) first = 4 * r + c;
    if (locked) begin
      empty = n == 0 ? empty + 1 : 0;
      if (empty >= DB) begin locked = 0; run = 0; end
    end else if (n == 1) begin
      run = (run > 0 && first == run_code) ? run + 1 : 1;
      run_code = first;
      if (run >= DB) begin
        locked = 1; empty = 0; run = 0; exp_kv = 1;
        exp_code = 4'(first);
        exp_seq = (exp_seq << 4) | N'(first);
        if (ndig < N / 4) ndig++;
      end
    end else run = 0;
    if (clr) begin exp_seq = '0; ndig = 0; end
  endtask

  task automatic run_round(input logic [15:0] k, input bit clr);
    pressed = k;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_high);
      #1;
      if (i == 0) exp_kv = 0;
      if (clr && i == 14) kif.clear = 1'b1;
      if (i == 15) kif.clear = 1'b0;
    end
    model_round(k, clr);
  endtask

  task automatic do_reset();
    @(negedge clk_high);
    #2 sys_rst_n = 1'b0;
    locked = 0; run = 0; empty = 0; ndig = 0; exp_kv = 0; exp_code = '0; exp_seq = '0;
    repeat (2) @(negedge clk_high);
    #2 sys_rst_n = 1'b1;
  endtask

  initial begin
    kif.clear = 1'b0;
    do_reset();
    chk("rst_col", kif.col, 4'hE);
    chk("rst_seq", kif.seq, '0);
    chk("rst_kv", kif.key_valid, 1'b0);
    chk("rst_code", kif.key_code, 4'h0);
    chk("rst_full", kif.full, 1'b0);
    repeat (2) run_round('0, 0);
    repeat (2) run_round(16'h0001, 0);
    run_round('0, 0);
    repeat (2) run_round(16'h0001, 0);
    repeat (4) run_round('0, 0);
    chk("bounce_seq", kif.seq, '0);
    repeat (8) run_round(16'h8002, 0);
    repeat (4) run_round('0, 0);
    chk("ghost_seq", kif.seq, '0);
    chk("ghost_code", kif.key_code, 4'h0);
    for (int i = 1; i <= 6; i++) begin
      run_round(16'h0040, 0);
      if (i == 4) begin
        chk("k6_valid", kif.key_valid, 1'b1);
        chk("k6_code", kif.key_code, 4'h6);
        chk("k6_seq", kif.seq, 32'h00000006);
      end
    end
    repeat (4) run_round('0, 0);
    repeat (4) run_round(16'h0400, 0);
    chk("k6a_seq", kif.seq, 32'h0000006A);
    repeat (4) run_round('0, 0);
    run_round('0, 1);
    chk("clr_seq", kif.seq, '0);
    for (int d = 1; d <= 9; d++) begin
      repeat (4) run_round(16'(1 << d), 0);
      if (d == 7) chk("ovf7_full", kif.full, 1'b0);
      if (d == 8) begin
        chk("ovf8_full", kif.full, 1'b1);
        chk("ovf8_seq", kif.seq, 32'h12345678);
      end
      if (d == 9) begin
        chk("ovf9_full", kif.full, 1'b1);
        chk("ovf9_seq", kif.seq, 32'h23456789);
      end
      repeat (4) run_round('0, 0);
    end
    repeat (3) run_round(16'h0020, 0);
    run_round(16'h0020, 1);
    chk("clr5_seq", kif.seq, '0);
    chk("clr5_full", kif.full, 1'b0);
    chk("clr5_valid", kif.key_valid, 1'b1);
    chk("clr5_code", kif.key_code, 4'h5);
    repeat (4) run_round('0, 0);
    repeat (3) run_round(16'h0008, 0);
    do_reset();
    chk("rrst_code", kif.key_code, 4'h0);
    for (int i = 1; i <= 4; i++) begin
      run_round(16'h0008, 0);
      chk("rrst_valid", kif.key_valid, i == 4);
    end
    chk("rrst_code3", kif.key_code, 4'h3);
    chk("rrst_seq", kif.seq, 32'h00000003);
    repeat (4) run_round('0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
